// File: rtl/eco32f_scoreboard.sv
// Per-register pending-result scoreboard beside decode; drives the ID->EX bubble.
// Optional WAW ordering check enabled by defining ECO32F_SB_WAW_EN.
module eco32f_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_stall,
    input  logic             id_flush,
    input  logic             pipe_stall,
    input  logic [AW-1:0]    id_rf_x_addr,
    input  logic             id_rf_x_used,
    input  logic [AW-1:0]    id_rf_y_addr,
    input  logic             id_rf_y_used,
    input  logic [AW-1:0]    id_rf_r_addr,
    input  logic             id_rf_r_we,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             wb_long_valid,
    input  logic [AW-1:0]    wb_long_addr,
    output logic             id_bubble,
    output logic [NREGS-1:0] sb_busy
);

    localparam logic [LAT_W-1:0] LONG = '1;
    localparam logic [LAT_W-1:0] ONE  = LAT_W'(1);

    logic [LAT_W-1:0] cnt_q [NREGS];
    logic [LAT_W-1:0] cnt_d [NREGS];

    logic hz_x, hz_y, hz_waw, hazard, issue, alloc;

    // A counter at 1 is covered by the EX forward path, so only values >1 stall a reader.
    always_comb begin
        hz_x   = 1'b0;
        hz_y   = 1'b0;
        hz_waw = 1'b0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (id_rf_x_addr == AW'(r) && cnt_q[r] > ONE) hz_x = 1'b1;
            if (id_rf_y_addr == AW'(r) && cnt_q[r] > ONE) hz_y = 1'b1;
`ifdef ECO32F_SB_WAW_EN
            if (id_rf_r_addr == AW'(r) && cnt_q[r] != '0 &&
                (cnt_q[r] == LONG || cnt_q[r] > id_lat)) hz_waw = 1'b1;
`endif
        end
        hazard    = (id_rf_x_used & hz_x) | (id_rf_y_used & hz_y) | (id_rf_r_we & hz_waw);
        id_bubble = id_valid & ~id_flush & hazard;
        issue     = id_valid & ~id_stall & ~id_flush & ~id_bubble;
        alloc     = issue & id_rf_r_we & (id_lat != '0);
    end

    // Later assignments win: allocate over release over drain.
    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!pipe_stall && cnt_q[r] != '0 && cnt_q[r] != LONG)
                cnt_d[r] = cnt_q[r] - ONE;
            if (wb_long_valid && wb_long_addr == AW'(r) && cnt_q[r] == LONG)
                cnt_d[r] = '0;
            if (alloc && id_rf_r_addr == AW'(r))
                cnt_d[r] = id_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        sb_busy = '0;
        for (int unsigned r = 1; r < NREGS; r++) sb_busy[r] = (cnt_q[r] != '0);
    end

endmodule

// File: tb/tb_eco32f_scoreboard.sv
// Scoreboard-style bench for eco32f_scoreboard: stimulus queues expectations, a monitor checks them.
module tb_eco32f_scoreboard;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int LAT_W = 3;
`ifdef ECO32F_SB_WAW_EN
    localparam logic WAW = 1'b1;
`else
    localparam logic WAW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0, id_stall = 1'b0, id_flush = 1'b0, pipe_stall = 1'b0;
    logic [AW-1:0]    id_rf_x_addr = '0, id_rf_y_addr = '0, id_rf_r_addr = '0, wb_long_addr = '0;
    logic             id_rf_x_used = 1'b0, id_rf_y_used = 1'b0, id_rf_r_we = 1'b0, wb_long_valid = 1'b0;
    logic [LAT_W-1:0] id_lat = '0;
    logic             id_bubble;
    logic [NREGS-1:0] sb_busy;

    always #5 clk = ~clk;

    eco32f_scoreboard #(.NREGS(NREGS), .AW(AW), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_stall(id_stall), .id_flush(id_flush), .pipe_stall(pipe_stall),
        .id_rf_x_addr(id_rf_x_addr), .id_rf_x_used(id_rf_x_used),
        .id_rf_y_addr(id_rf_y_addr), .id_rf_y_used(id_rf_y_used),
        .id_rf_r_addr(id_rf_r_addr), .id_rf_r_we(id_rf_r_we), .id_lat(id_lat),
        .wb_long_valid(wb_long_valid), .wb_long_addr(wb_long_addr),
        .id_bubble(id_bubble), .sb_busy(sb_busy)
    );

    typedef struct {
        logic        b;
        logic [31:0] busy;
        string       name;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            n_checks++;
            if (id_bubble !== e.b) begin
                n_fail++;
                $display("FAIL %s id_bubble got %0b expected %0b", e.name, id_bubble, e.b);
            end
            n_checks++;
            if (sb_busy !== e.busy) begin
                n_fail++;
                $display("FAIL %s sb_busy got %08h expected %08h", e.name, sb_busy, e.busy);
            end
        end
    end

    function automatic logic [31:0] B(input int n);
        return 32'(1) << n;
    endfunction

    task automatic push_exp(input logic eb, input logic [31:0] ebusy, input string nm);
        exp_t e;
        e.b = eb; e.busy = ebusy; e.name = nm;
        expq.push_back(e);
    endtask

    task automatic cyc(input logic v, input logic st, input logic fl, input logic ps,
                       input logic [4:0] x, input logic xu, input logic [4:0] y, input logic yu,
                       input logic [4:0] r, input logic we, input logic [2:0] lat,
                       input logic wbv, input logic [4:0] wba,
                       input logic eb, input logic [31:0] ebusy, input string nm);
        @(posedge clk); #1;
        id_valid = v; id_stall = st; id_flush = fl; pipe_stall = ps;
        id_rf_x_addr = x; id_rf_x_used = xu; id_rf_y_addr = y; id_rf_y_used = yu;
        id_rf_r_addr = r; id_rf_r_we = we; id_lat = lat;
        wb_long_valid = wbv; wb_long_addr = wba;
        push_exp(eb, ebusy, nm);
    endtask

    task automatic idl(input logic ps, input logic wbv, input logic [4:0] wba,
                       input logic [31:0] ebusy, input string nm);
        cyc(0, 0, 0, ps, 0, 0, 0, 0, 0, 0, 0, wbv, wba, 0, ebusy, nm);
    endtask

    task automatic wr(input logic [4:0] r, input logic [2:0] lat, input logic eb,
                      input logic [31:0] ebusy, input string nm);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, r, 1, lat, 0, 0, eb, ebusy, nm);
    endtask

    task automatic rdx(input logic [4:0] x, input logic ps, input logic eb,
                       input logic [31:0] ebusy, input string nm);
        cyc(1, 0, 0, ps, x, 1, 0, 0, 0, 0, 0, 0, 0, eb, ebusy, nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        idl(0, 0, 0, 32'h0, "reset_state");
        @(negedge clk); #1 rst_n = 1'b1;

        // load r5, immediate consumer
        wr(5, 1, 0, 32'h0, "load_issue");
        rdx(5, 0, 0, B(5), "load_use_no_bubble");
        idl(0, 0, 0, 32'h0, "load_drained");

        // mul r7, consumer on Y
        wr(7, 2, 0, 32'h0, "mul_issue");
        cyc(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, B(7), "mul_use_bubble");
        cyc(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, B(7), "mul_use_issue");
        idl(0, 0, 0, 32'h0, "mul_drained");

        // mul r7 with three pipe_stall cycles
        wr(7, 2, 0, 32'h0, "mul2_issue");
        for (int i = 0; i < 3; i++) rdx(7, 1, 1, B(7), "stall_bubble");
        rdx(7, 0, 1, B(7), "stall_extra_bubble");
        rdx(7, 0, 0, B(7), "stall_issue");
        idl(0, 0, 0, 32'h0, "mul2_drained");

        // divide r9, 20-cycle wait, release during pipe_stall
        wr(9, 7, 0, 32'h0, "div_issue");
        for (int i = 0; i < 20; i++) rdx(9, 0, 1, B(9), "div_wait");
        cyc(1, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 9, 1, B(9), "div_release_cycle");
        rdx(9, 0, 0, 32'h0, "div_after_release");

        // release of a short counter is ignored
        wr(9, 2, 0, 32'h0, "mul9_issue");
        idl(1, 1, 9, B(9), "release_ignored_short");
        rdx(9, 0, 1, B(9), "mul9_still_pending");
        idl(0, 0, 0, B(9), "mul9_last");
        idl(0, 0, 0, 32'h0, "mul9_drained");

        // r0, flush and id_stall never allocate
        wr(0, 2, 0, 32'h0, "r0_write");
        cyc(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, "r0_read");
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0, 32'h0, "flush_no_alloc");
        rdx(3, 0, 0, 32'h0, "after_flush");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 6, 1, 2, 0, 0, 0, 32'h0, "stall_no_alloc");
        rdx(6, 0, 0, 32'h0, "after_id_stall");

        // flush masks the bubble but in-flight entries keep draining
        wr(3, 2, 0, 32'h0, "mul3_issue");
        cyc(1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, B(3), "flush_masks_bubble");
        idl(0, 0, 0, B(3), "mul3_drains_through_flush");
        idl(0, 0, 0, 32'h0, "mul3_drained");

        // reallocation wins over a same-cycle drain
        wr(4, 2, 0, 32'h0, "mul4_issue");
        idl(0, 0, 0, B(4), "mul4_pending");
        wr(4, 2, 0, B(4), "realloc_on_drain");
        rdx(4, 0, 1, B(4), "realloc_bubble");
        idl(0, 0, 0, B(4), "realloc_last");
        idl(0, 0, 0, 32'h0, "realloc_drained");

        // short write behind a pending divide of the same register
        wr(9, 7, 0, 32'h0, "div9_issue");
        wr(9, 1, WAW, B(9), "waw_first");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 9, 1, 1, 1, 9, WAW, B(9), "waw_release");
        wr(9, 1, 0, WAW ? 32'h0 : B(9), "waw_third");
        idl(0, 0, 0, B(9), "waw_last");
        idl(0, 0, 0, 32'h0, "waw_drained");

        // asynchronous reset while a divide is pending
        wr(9, 7, 0, 32'h0, "div_for_reset");
        idl(0, 0, 0, B(9), "div_pending");
        @(posedge clk); #1;
        rst_n = 1'b0;
        id_valid = 1'b1; id_rf_x_addr = 9; id_rf_x_used = 1'b1;
        push_exp(0, 32'h0, "async_reset");
        @(negedge clk); #1 rst_n = 1'b1;
        rdx(9, 0, 0, 32'h0, "after_reset");
        idl(0, 0, 0, 32'h0, "final_idle");

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (expq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_queue pending %0d expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
